// File: rtl/i3c_sdr_write_sequencer.sv
// Sequences one I3C SDR private write frame (START, address+RW, ACK, data+T bytes, STOP)
// against single-cycle SCL edge strobes returned by the bus controller.
module i3c_sdr_write_sequencer #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic              scl_rise_i,
  input  logic              scl_fall_i,
  input  logic              sda_i,
  input  logic              abort_i,
  output logic [2:0]        state_o,
  output logic              sda_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              nack_o,
  output logic              err_o
);
  localparam int SH_W  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] T_BIT     = CNT_W'(DATA_W);

  // Encoding matches the controller's IDLE/START/ADDR/ACK/DATA/STOP codes.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_ADDR = 3'd2,
    S_ACK  = 3'd3, S_DATA  = 3'd4, S_STOP = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [SH_W-1:0]    sh, sh_d;
  logic [CNT_W-1:0]   bcnt, bcnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ack_q, ack_d, par_q, par_d;
  logic               nack_f, nack_fd, err_f, err_fd;
  logic               stop_rel, stop_rel_d;
  logic               sda_d, done_d, nack_d, err_d;
  logic               busy_q, done_q, nack_q, err_q, sda_q;
  logic               fall, rise, abort_pend, t_end, fetch;

  // A fall coinciding with a rise is treated as a rise only.
  assign rise = scl_rise_i;
  assign fall = scl_fall_i & ~scl_rise_i;

  always_comb begin
    abort_pend = err_f | abort_i;
    t_end      = (state == S_DATA) && fall && (bcnt == T_BIT);
    fetch      = fall && !abort_pend &&
                 (((state == S_ACK) && !ack_q && (len_q != '0)) ||
                  (t_end && (len_q > LEN_W'(1))));
  end

  // tx_ready must coincide with the fetching fall strobe, so it cannot be delayed a cycle.
  assign tx_ready_o = fetch;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      sh       <= '0;
      bcnt     <= '0;
      len_q    <= '0;
      ack_q    <= 1'b1;
      par_q    <= 1'b0;
      nack_f   <= 1'b0;
      err_f    <= 1'b0;
      stop_rel <= 1'b0;
      sda_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      sh       <= sh_d;
      bcnt     <= bcnt_d;
      len_q    <= len_d;
      ack_q    <= ack_d;
      par_q    <= par_d;
      nack_f   <= nack_fd;
      err_f    <= err_fd;
      stop_rel <= stop_rel_d;
      sda_q    <= sda_d;
      busy_q   <= (state_nxt != S_IDLE);
      done_q   <= done_d;
      nack_q   <= nack_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_i) state_nxt = S_START;
      S_START: if (fall) state_nxt = S_ADDR;
      S_ADDR:  if (fall && (bcnt == ADDR_LAST)) state_nxt = S_ACK;
      S_ACK:   if (fall) state_nxt = (fetch && tx_valid_i) ? S_DATA : S_STOP;
      S_DATA:  if (t_end) state_nxt = (fetch && tx_valid_i) ? S_DATA : S_STOP;
      S_STOP:  if (stop_rel) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (fall && abort_pend && (state != S_IDLE) && (state != S_STOP))
      state_nxt = S_STOP;
  end

  always_comb begin
    sh_d       = sh;
    bcnt_d     = bcnt;
    len_d      = len_q;
    ack_d      = ack_q;
    par_d      = par_q;
    nack_fd    = nack_f;
    err_fd     = err_f | (abort_i && (state != S_IDLE));
    stop_rel_d = stop_rel;
    sda_d      = sda_q;
    done_d     = 1'b0;
    nack_d     = 1'b0;
    err_d      = 1'b0;
    case (state)
      S_IDLE: if (req_i) begin
        sh_d = '0;
        sh_d[SH_W-1 -: ADDR_W+1] = {addr_i, 1'b0};
        len_d   = len_i;
        bcnt_d  = '0;
        nack_fd = 1'b0;
        err_fd  = 1'b0;
        sda_d   = 1'b0;
      end
      S_START: if (fall) begin
        sda_d  = sh[SH_W-1];
        bcnt_d = '0;
      end
      S_ADDR: if (fall) begin
        if (bcnt == ADDR_LAST) begin
          sda_d = 1'b1;
          ack_d = 1'b1;
        end else begin
          sh_d   = sh << 1;
          sda_d  = sh[SH_W-2];
          bcnt_d = bcnt + 1'b1;
        end
      end
      S_ACK: begin
        if (rise) ack_d = sda_i;
        if (fall && ack_q) nack_fd = 1'b1;
      end
      S_DATA: if (fall) begin
        if (bcnt < DATA_LAST) begin
          sh_d   = sh << 1;
          sda_d  = sh[SH_W-2];
          bcnt_d = bcnt + 1'b1;
        end else if (bcnt == DATA_LAST) begin
          sda_d  = par_q;
          bcnt_d = T_BIT;
        end else begin
          len_d = len_q - LEN_W'(1);
        end
      end
      S_STOP: begin
        if (stop_rel) begin
          done_d = 1'b1;
          nack_d = nack_f;
          err_d  = err_f;
        end else if (rise) begin
          sda_d      = 1'b1;
          stop_rel_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (fetch) begin
      if (tx_valid_i) begin
        sh_d = '0;
        sh_d[SH_W-1 -: DATA_W] = tx_data_i;
        sda_d  = tx_data_i[DATA_W-1];
        par_d  = ~^tx_data_i;
        bcnt_d = '0;
      end else begin
        err_fd = 1'b1;
      end
    end
    // Entering STOP: pull SDA low while SCL is low so the next rise can release it.
    if ((state != S_STOP) && (state_nxt == S_STOP)) begin
      sda_d      = 1'b0;
      stop_rel_d = 1'b0;
    end
  end

  assign state_o = state;
  assign sda_o   = sda_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign nack_o  = nack_q;
  assign err_o   = err_q;
endmodule

// File: tb/tb_i3c_sdr_write_sequencer.sv
// Directed bench for the I3C SDR write sequencer: drives SCL strobes, logs the SDA bit
// seen in each SCL high phase and checks frames, flags and fetch handshakes.
module tb_i3c_sdr_write_sequencer;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, ADDR = 3'd2,
                         ACK = 3'd3, DATA = 3'd4, STOP = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [6:0] addr;
  logic [3:0] len;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       scl_rise, scl_fall, sda_in, abort;
  logic [2:0] state;
  logic       sda, busy, done, nack, err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  bytes [0:3];
  int          idx, avail, rdy_cnt, np;
  logic [2:0]  st_log [0:63];
  logic [63:0] got_bits;

  always #5 clk = ~clk;

  i3c_sdr_write_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .len_i(len),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .scl_rise_i(scl_rise), .scl_fall_i(scl_fall), .sda_i(sda_in), .abort_i(abort),
    .state_o(state), .sda_o(sda), .busy_o(busy), .done_o(done), .nack_o(nack), .err_o(err)
  );

  task automatic load_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n_avail);
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = 8'h00;
    idx = 0; avail = n_avail; rdy_cnt = 0;
    tx_data = bytes[0];
    tx_valid = (avail > 0);
  endtask

  task automatic start_frame(input logic [6:0] a, input logic [3:0] l);
    @(negedge clk); addr = a; len = l; req = 1'b1;
    @(negedge clk); req = 1'b0;
  endtask

  // One SCL period: rise strobe, sample SDA in the high phase, fall strobe.
  task automatic scl_bit(input logic sdain);
    logic fetched;
    @(negedge clk); sda_in = sdain; scl_rise = 1'b1;
    @(negedge clk); scl_rise = 1'b0;
    st_log[np] = state;
    got_bits = {got_bits[62:0], sda};
    np++;
    @(negedge clk); scl_fall = 1'b1;
    #1 fetched = tx_ready;
    if (fetched) rdy_cnt++;
    @(negedge clk); scl_fall = 1'b0; sda_in = 1'b1;
    if (fetched) begin
      idx++;
      tx_data = bytes[idx];
      tx_valid = (idx < avail);
    end
  endtask

  task automatic run_periods(input int n, input int ack_at, input logic ack_val);
    np = 0; got_bits = '0;
    for (int p = 0; p < n; p++) scl_bit((p == ack_at) ? ack_val : 1'b1);
  endtask

  task automatic finish_stop(input string name, input logic exp_nack, input logic exp_err);
    n_cmp++;
    if (state !== STOP || sda !== 1'b0) begin
      n_bad++; $display("FAIL %s stop_entry: state=%0d sda=%b want state=%0d sda=0", name, state, sda, STOP);
    end
    @(negedge clk); scl_rise = 1'b1;
    @(negedge clk); scl_rise = 1'b0;
    n_cmp++;
    if (state !== STOP || sda !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL %s stop_release: state=%0d sda=%b done=%b want %0d/1/0", name, state, sda, done, STOP);
    end
    @(negedge clk);
    n_cmp++;
    if (state !== IDLE || done !== 1'b1 || nack !== exp_nack || err !== exp_err || busy !== 1'b0) begin
      n_bad++; $display("FAIL %s done_pulse: state=%0d done=%b nack=%b err=%b busy=%b want %0d/1/%b/%b/0",
                        name, state, done, nack, err, busy, IDLE, exp_nack, exp_err);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || nack !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL %s pulse_width: done=%b nack=%b err=%b want 0/0/0", name, done, nack, err);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = 1'b0; addr = '0; len = '0; tx_data = '0; tx_valid = 1'b0;
    scl_rise = 1'b0; scl_fall = 1'b0; sda_in = 1'b1; abort = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (state !== IDLE || sda !== 1'b1 || tx_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || nack !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: state=%0d sda=%b rdy=%b busy=%b done=%b nack=%b err=%b",
                        state, sda, tx_ready, busy, done, nack, err);
    end
    rst_n = 1'b1;
    // abort while idle must not leak an err flag into the next frame
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_cmp++;
    if (state !== IDLE || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_abort: state=%0d busy=%b want 0/0", state, busy);
    end
  endtask

  task automatic test_single_byte(input string name);
    logic [18:0] exp_bits;
    int bad_st;
    exp_bits = {1'b0, 8'b0101_0100, 1'b1, 8'hA5, 1'b1};
    load_bytes(8'hA5, 8'h00, 8'h00, 1);
    start_frame(7'h2A, 4'd1);
    n_cmp++;
    if (state !== START || sda !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL %s start: state=%0d sda=%b busy=%b want %0d/0/1", name, state, sda, busy, START);
    end
    run_periods(19, 9, 1'b0);
    n_cmp++;
    if (got_bits[18:0] !== exp_bits) begin
      n_bad++; $display("FAIL %s sda_stream: got %b want %b", name, got_bits[18:0], exp_bits);
    end
    bad_st = 0;
    for (int i = 0; i < 19; i++)
      if (st_log[i] !== ((i == 0) ? START : (i <= 8) ? ADDR : (i == 9) ? ACK : DATA)) bad_st++;
    n_cmp++;
    if (bad_st != 0) begin
      n_bad++; $display("FAIL %s state_seq: %0d periods in wrong state, want 0", name, bad_st);
    end
    n_cmp++;
    if (rdy_cnt != 1) begin
      n_bad++; $display("FAIL %s ready_count: got %0d want 1", name, rdy_cnt);
    end
    finish_stop(name, 1'b0, 1'b0);
  endtask

  task automatic test_nack;
    logic [9:0] exp_bits;
    exp_bits = {1'b0, 8'b1010_0000, 1'b1};
    load_bytes(8'h11, 8'h22, 8'h33, 3);
    start_frame(7'h50, 4'd2);
    run_periods(10, 9, 1'b1);
    n_cmp++;
    if (got_bits[9:0] !== exp_bits || st_log[9] !== ACK) begin
      n_bad++; $display("FAIL nack_stream: got %b st=%0d want %b st=%0d", got_bits[9:0], st_log[9], exp_bits, ACK);
    end
    n_cmp++;
    if (rdy_cnt != 0) begin
      n_bad++; $display("FAIL nack_ready: got %0d want 0", rdy_cnt);
    end
    finish_stop("nack", 1'b1, 1'b0);
  endtask

  task automatic test_multi_byte;
    logic [26:0] exp_bits;
    int n_data;
    exp_bits = {8'h00, 1'b1, 8'hFF, 1'b1, 8'h81, 1'b1};
    load_bytes(8'h00, 8'hFF, 8'h81, 3);
    start_frame(7'h13, 4'd3);
    run_periods(37, 9, 1'b0);
    n_cmp++;
    if (got_bits[26:0] !== exp_bits) begin
      n_bad++; $display("FAIL multi_data_bits: got %b want %b", got_bits[26:0], exp_bits);
    end
    n_data = 0;
    for (int i = 0; i < 37; i++) if (st_log[i] === DATA) n_data++;
    n_cmp++;
    if (n_data != 27) begin
      n_bad++; $display("FAIL multi_data_periods: got %0d want 27", n_data);
    end
    n_cmp++;
    if (rdy_cnt != 3) begin
      n_bad++; $display("FAIL multi_ready: got %0d want 3", rdy_cnt);
    end
    finish_stop("multi", 1'b0, 1'b0);
  endtask

  task automatic test_underrun;
    load_bytes(8'h3C, 8'h00, 8'h00, 1);
    start_frame(7'h22, 4'd2);
    run_periods(19, 9, 1'b0);
    n_cmp++;
    if (rdy_cnt != 2 || got_bits[8:0] !== {8'h3C, 1'b1}) begin
      n_bad++; $display("FAIL underrun_fetch: rdy=%0d bits=%b want 2 %b", rdy_cnt, got_bits[8:0], {8'h3C, 1'b1});
    end
    finish_stop("underrun", 1'b0, 1'b1);
  endtask

  task automatic test_abort;
    load_bytes(8'hC3, 8'h5A, 8'h00, 2);
    start_frame(7'h31, 4'd2);
    run_periods(13, 9, 1'b0);
    // bit counter now at 3; a second request must be ignored while busy
    @(negedge clk); abort = 1'b1; req = 1'b1; addr = 7'h7F; len = 4'd1;
    @(negedge clk); abort = 1'b0; req = 1'b0;
    n_cmp++;
    if (state !== DATA || busy !== 1'b1) begin
      n_bad++; $display("FAIL abort_hold: state=%0d busy=%b want %0d/1", state, busy, DATA);
    end
    np = 0;
    scl_bit(1'b1);
    n_cmp++;
    if (st_log[0] !== DATA || got_bits[0] !== 1'b0) begin
      n_bad++; $display("FAIL abort_bit3: state=%0d sda=%b want %0d/0", st_log[0], got_bits[0], DATA);
    end
    finish_stop("abort", 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (state !== IDLE || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_no_restart: state=%0d busy=%b want 0/0", state, busy);
    end
  endtask

  task automatic test_reset_mid_frame;
    load_bytes(8'hF0, 8'h00, 8'h00, 1);
    start_frame(7'h44, 4'd1);
    run_periods(12, 9, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state !== IDLE || sda !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid: state=%0d sda=%b busy=%b want 0/1/0", state, sda, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    test_single_byte("after_reset");
  endtask

  initial begin
    test_reset();
    test_single_byte("single");
    test_nack();
    test_multi_byte();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
